// File: rtl/sr_pkg.sv
// Shared definitions for the serial shift-register loaders: sequencer state
// encoding plus small constant helpers for sizing counters.
package sr_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t CLEAR    = 3'd1;
    localparam state_t SHIFT_LO = 3'd2;
    localparam state_t SHIFT_HI = 3'd3;
    localparam state_t LATCH    = 3'd4;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter timing one shift/clear/latch phase; tc is high while
// the count sits at zero, and the count parks there instead of wrapping.
module sr_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sr_chain_loader.sv
// Serial loader for daisy-chained 74HC595-style registers: all channels shift
// in lockstep on a shared SHCP, then a shared STCP pulse latches the chains.
module sr_chain_loader
    import sr_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int WIDTH          = 56,
    parameter int HALF_PERIOD    = 1,
    parameter int LATCH_CYCLES   = 1,
    parameter int MSB_FIRST      = 0,
    parameter int CLEAR_ON_START = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [NUM_CH*WIDTH-1:0] data,
    output logic                    ready,
    output logic                    done,
    output logic [NUM_CH-1:0]       DS,
    output logic                    SHCP,
    output logic                    STCP,
    output logic                    MR
);

    localparam int KW = (WIDTH > 1) ? clog2(WIDTH) : 1;
    localparam int TW = clog2(max2(HALF_PERIOD, LATCH_CYCLES) + 1);

    localparam logic [KW-1:0] LAST_BIT = KW'(WIDTH - 1);
    localparam logic [TW-1:0] HP_LOAD  = TW'(HALF_PERIOD - 1);
    localparam logic [TW-1:0] LAT_LOAD = TW'(LATCH_CYCLES - 1);

    state_t                    state;
    state_t                    state_next;
    logic [KW-1:0]             bit_idx;
    logic [KW-1:0]             bit_idx_next;
    logic [KW-1:0]             bit_sel;
    logic [NUM_CH*WIDTH-1:0]   shadow;
    logic [NUM_CH*WIDTH-1:0]   shadow_next;
    logic [NUM_CH-1:0]         ds_shift;
    logic                      accept;
    logic                      timer_load;
    logic [TW-1:0]             timer_value;
    logic                      timer_tc;

    logic                      ready_next;
    logic                      done_next;
    logic [NUM_CH-1:0]         ds_next;
    logic                      shcp_next;
    logic                      stcp_next;
    logic                      mr_next;

    assign accept = start && ready;

    // Each phase is timed from the transition into it, so the timer reloads on every state change.
    assign timer_load  = (state_next != state);
    assign timer_value = (state_next == LATCH) ? LAT_LOAD : HP_LOAD;

    sr_phase_timer #(
        .W (TW)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .tc         (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_idx <= '0;
            shadow  <= '0;
            ready   <= 1'b0;
            done    <= 1'b0;
            DS      <= '0;
            SHCP    <= 1'b0;
            STCP    <= 1'b0;
            MR      <= 1'b1;
        end else begin
            state   <= state_next;
            bit_idx <= bit_idx_next;
            shadow  <= shadow_next;
            ready   <= ready_next;
            done    <= done_next;
            DS      <= ds_next;
            SHCP    <= shcp_next;
            STCP    <= stcp_next;
            MR      <= mr_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        shadow_next  = shadow;
        case (state)
            IDLE: begin
                if (accept) begin
                    shadow_next  = data;
                    bit_idx_next = '0;
                    state_next   = (CLEAR_ON_START != 0) ? CLEAR : SHIFT_LO;
                end
            end
            CLEAR: begin
                if (timer_tc) state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (timer_tc) state_next = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (timer_tc) begin
                    if (bit_idx == LAST_BIT) begin
                        state_next = LATCH;
                    end else begin
                        bit_idx_next = bit_idx + KW'(1);
                        state_next   = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (timer_tc) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so they register in step with it.
    assign bit_sel = (MSB_FIRST != 0) ? (LAST_BIT - bit_idx_next) : bit_idx_next;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_channel
        logic [WIDTH-1:0] slice;
        assign slice       = shadow_next[c*WIDTH +: WIDTH];
        assign ds_shift[c] = slice[bit_sel];
    end

    always_comb begin
        ready_next = (state_next == IDLE);
        done_next  = (state == LATCH) && (state_next == IDLE);
        shcp_next  = (state_next == SHIFT_HI);
        stcp_next  = (state_next == LATCH);
        mr_next    = (state_next != CLEAR);
        ds_next    = '0;
        if (state_next == SHIFT_LO || state_next == SHIFT_HI) begin
            ds_next = ds_shift;
        end else if (state_next == LATCH) begin
            ds_next = DS;
        end
    end

endmodule
